// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the packet-aware round-robin AXI-Stream switch.
// TDEST range decoding lives here so every slave lane decodes identically.
package axis_switch_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns the owning master index, or -1 when the destination is undecodable.
  function automatic int dest_decode(input logic [31:0] dest, input int base,
                                     input int stride, input int rng, input int nmasters);
    int off;
    int m;
    off = int'(dest) - base;
    if (off < 0) return -1;
    m = off / stride;
    if ((m >= nmasters) || ((off - m * stride) > rng)) return -1;
    return m;
  endfunction

endpackage

// File: rtl/axis_sw_out_fifo.sv
// Per-master output FIFO; read data comes straight from the storage registers,
// so it holds steady while the downstream stalls.
module axis_sw_out_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  entry_t wr_data,
  output logic   full,
  output logic   rd_valid,
  input  logic   rd_ready,
  output entry_t rd_data
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign do_rd    = rd_valid && rd_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr    = wr_en && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_switch_pkt_rrobin.sv
// NxM AXI-Stream switch: TDEST range routing, per-master round-robin with the
// grant held until TLAST, undecodable beats dropped, buffered master outputs.
//
//   state     | meaning
//   ST_IDLE   | no packet open; round-robin picks among decoded requesters
//   ST_LOCKED | packet open; only the granted slave is served until TLAST
module axis_switch_pkt_rrobin
  import axis_switch_pkg::*;
#(
  parameter int NSLAVES     = 2,
  parameter int NMASTERS    = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int HAS_ID      = 0,
  parameter int HAS_LAST    = 1,
  parameter int HAS_DEST    = 1,
  parameter int DEST_BASE   = 0,
  parameter int DEST_STRIDE = 1,
  parameter int DEST_RANGE  = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NSLAVES-1:0]             s_valid,
  output logic [NSLAVES-1:0]             s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0]  s_data,
  input  logic [NSLAVES*ID_WIDTH-1:0]    s_id,
  input  logic [NSLAVES*DEST_WIDTH-1:0]  s_dest,
  input  logic [NSLAVES-1:0]             s_last,
  output logic [NMASTERS-1:0]            m_valid,
  input  logic [NMASTERS-1:0]            m_ready,
  output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
  output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
  output logic [NMASTERS-1:0]            m_last,
  output logic [NSLAVES-1:0]             dec_err
);

  localparam int SW = idx_width(NSLAVES);
  localparam int MW = idx_width(NMASTERS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic                  last;
  } entry_t;

  logic [NSLAVES-1:0]          dec_ok;
  logic [NSLAVES*MW-1:0]       dec_m;
  logic [NSLAVES-1:0]          slave_locked;
  logic [NSLAVES-1:0]          drop;
  logic [NMASTERS-1:0]         locked_v;
  logic [NMASTERS*SW-1:0]      gnt_flat;
  logic [NMASTERS*NSLAVES-1:0] gnt_rdy;

  always_comb begin
    int dm;
    dm     = 0;
    dec_ok = '0;
    dec_m  = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      dm = (HAS_DEST != 0)
           ? dest_decode(32'(s_dest[i*DEST_WIDTH +: DEST_WIDTH]), DEST_BASE,
                         DEST_STRIDE, DEST_RANGE, NMASTERS)
           : 0;
      dec_ok[i]          = (dm >= 0);
      dec_m[i*MW +: MW]  = (dm >= 0) ? MW'(dm) : '0;
    end
  end

  always_comb begin
    slave_locked = '0;
    for (int m = 0; m < NMASTERS; m++)
      for (int i = 0; i < NSLAVES; i++)
        if (locked_v[m] && (gnt_flat[m*SW +: SW] == SW'(i))) slave_locked[i] = 1'b1;
  end

  // A slave holding a packet lock is never dropped, whatever its TDEST says.
  assign drop = s_valid & ~slave_locked & ~dec_ok;

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      s_ready[i] = drop[i];
      for (int m = 0; m < NMASTERS; m++) s_ready[i] = s_ready[i] | gnt_rdy[m*NSLAVES + i];
    end
    if (areset) s_ready = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) dec_err <= '0;
    else        dec_err <= drop;
  end

  for (genvar m = 0; m < NMASTERS; m++) begin : g_mst
    arb_state_t         state_q, state_d;
    logic [SW-1:0]      gnt_q, gnt_d, ptr_q, ptr_d, win, sel;
    logic [NSLAVES-1:0] req, rdy;
    logic               found, sel_ok, full, wr, beat_last;
    entry_t             wr_entry, rd_entry;

    always_comb begin
      req   = '0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NSLAVES; i++)
        req[i] = s_valid[i] && dec_ok[i] && (dec_m[i*MW +: MW] == MW'(m)) && !slave_locked[i];
      for (int k = 0; k < NSLAVES; k++) begin
        if (!found && req[(int'(ptr_q) + k) % NSLAVES]) begin
          found = 1'b1;
          win   = SW'((int'(ptr_q) + k) % NSLAVES);
        end
      end
    end

    assign sel       = (state_q == ST_LOCKED) ? gnt_q : win;
    assign sel_ok    = (state_q == ST_LOCKED) || found;
    assign wr        = sel_ok && s_valid[sel] && !full;
    assign beat_last = (HAS_LAST != 0) ? s_last[sel] : 1'b1;

    always_comb begin
      rdy = '0;
      if (sel_ok && !full) rdy[sel] = 1'b1;
    end

    assign gnt_rdy[m*NSLAVES +: NSLAVES] = rdy;
    assign locked_v[m]                   = (state_q == ST_LOCKED);
    assign gnt_flat[m*SW +: SW]          = gnt_q;

    always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      if (wr) begin
        if (beat_last) begin
          state_d = ST_IDLE;
          ptr_d   = SW'((int'(sel) + 1) % NSLAVES);
        end else begin
          state_d = ST_LOCKED;
          gnt_d   = sel;
        end
      end
    end

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        state_q <= ST_IDLE;
        gnt_q   <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        gnt_q   <= gnt_d;
        ptr_q   <= ptr_d;
      end
    end

    always_comb begin
      wr_entry.data = s_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      wr_entry.id   = (HAS_ID != 0) ? s_id[int'(sel)*ID_WIDTH +: ID_WIDTH] : '0;
      wr_entry.dest = s_dest[int'(sel)*DEST_WIDTH +: DEST_WIDTH];
      wr_entry.last = beat_last;
    end

    axis_sw_out_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (aclk),
      .rst      (areset),
      .wr_en    (wr),
      .wr_data  (wr_entry),
      .full     (full),
      .rd_valid (m_valid[m]),
      .rd_ready (m_ready[m]),
      .rd_data  (rd_entry)
    );

    assign m_data[m*DATA_WIDTH +: DATA_WIDTH] = rd_entry.data;
    assign m_id[m*ID_WIDTH +: ID_WIDTH]       = rd_entry.id;
    assign m_dest[m*DEST_WIDTH +: DEST_WIDTH] = rd_entry.dest;
    assign m_last[m]                          = rd_entry.last;
  end

endmodule

// File: tb/tb_axis_switch_pkt_rrobin.sv
// Bench for the packet round-robin switch: directed scenarios plus a random
// traffic run checked against a per-(slave,master) packet-order scoreboard.
module tb_axis_switch_pkt_rrobin;

  localparam int NS = 2;
  localparam int NM = 2;
  localparam int DW = 64;
  localparam int IW = 1;
  localparam int TW = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NS-1:0]     s_valid, s_ready, s_last, dec_err;
  logic [NS*DW-1:0]  s_data;
  logic [NS*IW-1:0]  s_id;
  logic [NS*TW-1:0]  s_dest;
  logic [NM-1:0]     m_valid, m_ready, m_last;
  logic [NM*DW-1:0]  m_data;
  logic [NM*IW-1:0]  m_id;
  logic [NM*TW-1:0]  m_dest;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
    logic          last;
    logic          bad;
  } tbeat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
    logic          last;
  } obeat_t;

  tbeat_t tx_q  [NS][$];
  obeat_t exp_q [NS][NM][$];

  // Masters own dest 4 (M0) and 6 (M1); everything else is undecodable.
  axis_switch_pkt_rrobin #(
    .NSLAVES(NS), .NMASTERS(NM), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(TW),
    .HAS_ID(0), .HAS_LAST(1), .HAS_DEST(1), .DEST_BASE(4), .DEST_STRIDE(2),
    .DEST_RANGE(0), .FIFO_DEPTH(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id),
    .s_dest(s_dest), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .m_dest(m_dest), .m_last(m_last), .dec_err(dec_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] mk(input int s, input int n);
    return {8'(s), 24'(0), 32'(n)};
  endfunction

  task automatic drive_idle();
    s_valid = '0; s_last = '0; s_data = '0; s_id = '0; s_dest = '0; m_ready = '0;
  endtask

  task automatic set_beat(input int s, input logic v, input logic [TW-1:0] d,
                          input logic [DW-1:0] dat, input logic l);
    s_valid[s]           = v;
    s_dest[s*TW +: TW]   = d;
    s_data[s*DW +: DW]   = dat;
    s_last[s]            = l;
    s_id[s]              = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    drive_idle();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    areset = 1'b1;
    set_beat(0, 1'b1, 8'd4, mk(0, 0), 1'b1);
    set_beat(1, 1'b1, 8'd6, mk(1, 0), 1'b1);
    m_ready = '1;
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if (m_valid !== '0 || s_ready !== '0 || dec_err !== '0 || m_data !== '0 || m_last !== '0) begin
      miscompares++;
      $display("FAIL reset_state: m_valid=%b s_ready=%b dec_err=%b m_last=%b m_data=%h, required all zero",
               m_valid, s_ready, dec_err, m_last, m_data);
    end
    drive_idle();
    @(posedge aclk);
    #1 areset = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      vectors++;
      if (m_valid !== '0 || s_ready !== '0) begin
        miscompares++;
        $display("FAIL reset_idle: m_valid=%b s_ready=%b, required 00 00", m_valid, s_ready);
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [DW-1:0] expd [$];
    int            cnt [NS];
    logic [NS-1:0] acc;
    logic [1:0]    exp_r;
    do_reset();
    m_ready = '1;
    for (int s = 0; s < NS; s++) begin
      cnt[s] = 0;
      set_beat(s, 1'b1, 8'd4, mk(s, 0), 1'b1);
    end
    for (int k = 0; k < 8; k++) expd.push_back(mk(k % 2, k / 2));
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      if (c < 8) begin
        exp_r = 2'(1 << (c % 2));
        vectors++;
        if (s_ready !== exp_r) begin
          miscompares++;
          $display("FAIL rr_ready cyc=%0d: got %b required %b", c, s_ready, exp_r);
        end
      end
      if (c >= 1) begin
        vectors++;
        if (m_valid !== 2'b01 || m_data[0 +: DW] !== expd[c-1]) begin
          miscompares++;
          $display("FAIL rr_order cyc=%0d: m_valid=%b data=%h required valid=01 data=%h",
                   c, m_valid, m_data[0 +: DW], expd[c-1]);
        end
      end
      acc = s_valid & s_ready;
      @(posedge aclk);
      #1;
      for (int s = 0; s < NS; s++)
        if (acc[s]) begin
          cnt[s]++;
          set_beat(s, 1'b1, 8'd4, mk(s, cnt[s]), 1'b1);
        end
    end
    drive_idle();
  endtask

  task automatic test_packet_lock();
    logic [DW-1:0] expd [$];
    logic [NS-1:0] acc;
    int            n0;
    do_reset();
    m_ready = '1;
    n0 = 0;
    set_beat(0, 1'b1, 8'd4, mk(0, 0), 1'b0);
    for (int k = 0; k < 4; k++) expd.push_back(mk(0, k));
    expd.push_back(mk(1, 0));
    for (int c = 0; c < 7; c++) begin
      @(negedge aclk);
      if (c >= 1 && c <= 4) begin
        vectors++;
        if (s_ready[1] !== (c == 4)) begin
          miscompares++;
          $display("FAIL lock_s1_ready cyc=%0d: got %b required %b", c, s_ready[1], (c == 4));
        end
      end
      if (c >= 1 && c <= 5) begin
        vectors++;
        if (m_valid[0] !== 1'b1 || m_data[0 +: DW] !== expd[c-1] || m_last[0] !== (c >= 4)) begin
          miscompares++;
          $display("FAIL lock_order cyc=%0d: valid=%b data=%h last=%b required 1 %h %b",
                   c, m_valid[0], m_data[0 +: DW], m_last[0], expd[c-1], (c >= 4));
        end
      end
      acc = s_valid & s_ready;
      @(posedge aclk);
      #1;
      if (acc[0]) begin
        n0++;
        if (n0 < 4) set_beat(0, 1'b1, 8'd4, mk(0, n0), n0 == 3);
        else        s_valid[0] = 1'b0;
      end
      if (acc[1]) s_valid[1] = 1'b0;
      if (c == 0) set_beat(1, 1'b1, 8'd4, mk(1, 0), 1'b1);
    end
    drive_idle();
  endtask

  task automatic test_decode_error();
    do_reset();
    m_ready = '1;
    set_beat(0, 1'b1, 8'd5, mk(0, 0), 1'b1);
    @(negedge aclk);
    vectors++;
    if (s_ready !== 2'b01 || dec_err !== '0) begin
      miscompares++;
      $display("FAIL dec_drop_ready: s_ready=%b dec_err=%b required 01 00", s_ready, dec_err);
    end
    @(posedge aclk);
    #1 s_valid = '0;
    @(negedge aclk);
    vectors++;
    if (dec_err !== 2'b01 || m_valid !== '0) begin
      miscompares++;
      $display("FAIL dec_pulse: dec_err=%b m_valid=%b required 01 00", dec_err, m_valid);
    end
    @(negedge aclk);
    vectors++;
    if (dec_err !== '0 || m_valid !== '0) begin
      miscompares++;
      $display("FAIL dec_single: dec_err=%b m_valid=%b required 00 00", dec_err, m_valid);
    end
    @(posedge aclk);
    #1 set_beat(0, 1'b1, 8'd6, mk(0, 1), 1'b1);
    @(negedge aclk);
    vectors++;
    if (s_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_m1_ready: got %b required 1", s_ready[0]);
    end
    @(posedge aclk);
    #1 s_valid = '0;
    @(negedge aclk);
    vectors++;
    if (m_valid !== 2'b10 || m_data[DW +: DW] !== mk(0, 1) || m_dest[TW +: TW] !== 8'd6 || dec_err !== '0) begin
      miscompares++;
      $display("FAIL dec_m1_deliver: m_valid=%b data=%h dest=%0d dec_err=%b required 10 %h 6 00",
               m_valid, m_data[DW +: DW], m_dest[TW +: TW], dec_err, mk(0, 1));
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    int   n, accepted, rx;
    logic acc;
    do_reset();
    n = 0;
    accepted = 0;
    set_beat(0, 1'b1, 8'd4, mk(0, 0), 1'b1);
    repeat (10) begin
      @(negedge aclk);
      acc = s_valid[0] && s_ready[0];
      if (acc) accepted++;
      @(posedge aclk);
      #1;
      if (acc) begin
        n++;
        set_beat(0, 1'b1, 8'd4, mk(0, n), 1'b1);
      end
    end
    @(negedge aclk);
    vectors++;
    if (accepted != 4 || s_ready[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0 +: DW] !== mk(0, 0)) begin
      miscompares++;
      $display("FAIL bp_fill: accepted=%0d s_ready=%b m_valid=%b head=%h required 4 0 1 %h",
               accepted, s_ready[0], m_valid[0], m_data[0 +: DW], mk(0, 0));
    end
    @(posedge aclk);
    #1 m_ready[0] = 1'b1;
    rx = 0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      @(negedge aclk);
      acc = s_valid[0] && s_ready[0];
      if (m_valid[0] && m_ready[0]) begin
        vectors++;
        if (m_data[0 +: DW] !== mk(0, rx)) begin
          miscompares++;
          $display("FAIL bp_order idx=%0d: got %h required %h", rx, m_data[0 +: DW], mk(0, rx));
        end
        rx++;
      end
      @(posedge aclk);
      #1;
      if (acc) begin
        n++;
        if (n < 8) set_beat(0, 1'b1, 8'd4, mk(0, n), 1'b1);
        else       s_valid[0] = 1'b0;
      end
    end
    repeat (2) @(negedge aclk);
    vectors++;
    if (rx != 8 || m_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: received=%0d m_valid=%b required 8 0", rx, m_valid[0]);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_packet();
    int   n;
    logic acc;
    do_reset();
    n = 0;
    set_beat(0, 1'b1, 8'd4, mk(0, 0), 1'b0);
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge aclk);
      acc = s_valid[0] && s_ready[0];
      @(posedge aclk);
      #1;
      if (acc) begin
        n++;
        set_beat(0, 1'b1, 8'd4, mk(0, n), n == 3);
      end
    end
    vectors++;
    if (n != 2 || m_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: beats=%0d m_valid=%b required 2 1", n, m_valid[0]);
    end
    areset = 1'b1;
    #2;
    vectors++;
    if (m_valid !== '0) begin
      miscompares++;
      $display("FAIL mid_async_clear: m_valid=%b required 00", m_valid);
    end
    drive_idle();
    @(posedge aclk);
    #1 areset = 1'b0;
    m_ready = '1;
    set_beat(1, 1'b1, 8'd4, mk(1, 0), 1'b1);
    @(negedge aclk);
    vectors++;
    if (s_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_regrant: s_ready=%b required 10", s_ready);
    end
    @(posedge aclk);
    #1 s_valid = '0;
    @(negedge aclk);
    vectors++;
    if (m_valid !== 2'b01 || m_data[0 +: DW] !== mk(1, 0)) begin
      miscompares++;
      $display("FAIL mid_deliver: m_valid=%b data=%h required 01 %h", m_valid, m_data[0 +: DW], mk(1, 0));
    end
    @(negedge aclk);
    vectors++;
    if (m_valid !== '0) begin
      miscompares++;
      $display("FAIL mid_no_replay: m_valid=%b required 00", m_valid);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [TW-1:0] bad_d [5];
    logic [NS-1:0] acc, pend;
    logic [NM-1:0] in_pkt;
    int            cur_src [NM];
    int            seq, mst, len, src, left;
    logic          done;
    obeat_t        got;
    bad_d = '{8'd0, 8'd3, 8'd5, 8'd7, 8'd100};
    do_reset();
    seq = 0;
    for (int i = 0; i < NS; i++) begin
      for (int p = 0; p < 40; p++) begin
        if ($urandom_range(0, 5) == 0) begin
          tx_q[i].push_back('{data: mk(i, seq), dest: bad_d[$urandom_range(0, 4)], last: 1'b1, bad: 1'b1});
          seq++;
        end else begin
          mst = $urandom_range(0, NM - 1);
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            tbeat_t t;
            t.data = mk(i, seq);
            t.dest = (b == 0) ? TW'(4 + 2 * mst) : TW'($urandom_range(0, 255));
            t.last = (b == len - 1);
            t.bad  = 1'b0;
            tx_q[i].push_back(t);
            exp_q[i][mst].push_back('{data: t.data, dest: t.dest, last: t.last});
            seq++;
          end
        end
      end
    end
    pend   = '0;
    in_pkt = '0;
    for (int m = 0; m < NM; m++) cur_src[m] = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge aclk);
      for (int i = 0; i < NS; i++) begin
        vectors++;
        if (dec_err[i] !== pend[i]) begin
          miscompares++;
          $display("FAIL rand_dec_err cyc=%0d s=%0d: got %b required %b", cyc, i, dec_err[i], pend[i]);
        end
      end
      acc = s_valid & s_ready;
      for (int i = 0; i < NS; i++) pend[i] = acc[i] ? tx_q[i][0].bad : 1'b0;
      for (int m = 0; m < NM; m++) begin
        if (m_valid[m] && m_ready[m]) begin
          got = {m_data[m*DW +: DW], m_dest[m*TW +: TW], m_last[m]};
          src = int'(got.data[DW-1 -: 8]);
          vectors++;
          if (src >= NS || exp_q[src % NS][m].size() == 0) begin
            miscompares++;
            $display("FAIL rand_unexpected m=%0d: got %h required no beat", m, got);
          end else begin
            if (got !== exp_q[src][m][0] || m_id[m] !== 1'b0 || (in_pkt[m] && cur_src[m] != src)) begin
              miscompares++;
              $display("FAIL rand_beat m=%0d: got %h id=%b src=%0d required %h id=0 src=%0d",
                       m, got, m_id[m], src, exp_q[src][m][0], in_pkt[m] ? cur_src[m] : src);
            end
            void'(exp_q[src][m].pop_front());
          end
          in_pkt[m]  = !got.last;
          cur_src[m] = src;
        end
      end
      left = 0;
      for (int i = 0; i < NS; i++) begin
        left += tx_q[i].size();
        for (int m = 0; m < NM; m++) left += exp_q[i][m].size();
      end
      done = (left == 0) && (m_valid == '0) && (pend == '0) && (acc == '0);
      if (done) break;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          void'(tx_q[i].pop_front());
          s_valid[i] = 1'b0;
        end
        if (!s_valid[i] && tx_q[i].size() > 0 && $urandom_range(0, 3) != 0)
          set_beat(i, 1'b1, tx_q[i][0].dest, tx_q[i][0].data, tx_q[i][0].last);
      end
      for (int m = 0; m < NM; m++) m_ready[m] = ($urandom_range(0, 3) != 0);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL rand_drain: %0d beats outstanding, required 0", left);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_packet_lock();
    test_decode_error();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
